ccff_bitstream_loader: RTL and testbench

- Initiator side of the configuration-chain protocol; the logic tiles' chains are the responders.
- Accepts configuration words over a valid/ready stream and serializes them MSB-first onto `ccff_head`, qualified by a shift enable, for exactly CHAIN_LEN bits.
- Observes `ccff_tail` so the loaded image can be read back and checked.
- Sits between the bitstream source (SPI/host bridge) and the head of the fabric configuration chain.

---
 rtl/ccff_bitstream_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain initiator: accepts valid/ready words and shifts them MSB-first onto ccff_head.
// Define CCFF_READBACK_CRC_EN to add a full-rotation readback pass with CRC-8 compare.
module ccff_bitstream_loader #(
   parameter int unsigned CHAIN_LEN = 64,
   parameter int unsigned WORD_W    = 8,
   parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              ccff_head,
   output logic              ccff_en,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int unsigned NumWords = (CHAIN_LEN + WORD_W - 1) / WORD_W;
   localparam int unsigned WcntW    = $clog2(NumWords + 1);
   localparam int unsigned SlW      = $clog2(WORD_W + 1);

   typedef enum logic [1:0] {StIdle, StLoad, StRback, StFin} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WcntW-1:0]  wcnt_q, wcnt_d;
   logic [WORD_W-1:0] shreg_q, shreg_d;
   logic [WORD_W-1:0] buf_q, buf_d;
   logic              buf_full_q, buf_full_d;
   // Unshifted bits left in shreg; zero means the shifter is starved.
   logic [SlW-1:0]    sh_left_q, sh_left_d;

   logic              shift;
   logic              accept;
   logic              shreg_empty;
   int unsigned       rem;
   logic [SlW-1:0]    load_n;

`ifdef CCFF_READBACK_CRC_EN
   logic [7:0]       crc_ld_q, crc_ld_d;
   logic [7:0]       crc_rb_q, crc_rb_d;
   logic [CNT_W-1:0] rb_cnt_q, rb_cnt_d;
   logic             error_q, error_d;

   // Bit-serial CRC-8, polynomial x^8 + x^2 + x + 1.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
   endfunction

   assign error = error_q;
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign error       = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      wcnt_d      = wcnt_q;
      shreg_d     = shreg_q;
      buf_d       = buf_q;
      buf_full_d  = buf_full_q;
      sh_left_d   = sh_left_q;
      cfg_ready   = 1'b0;
      ccff_en     = 1'b0;
      ccff_head   = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      shift       = 1'b0;
      accept      = 1'b0;
      shreg_empty = 1'b0;
      rem         = 0;
      load_n      = '0;
`ifdef CCFF_READBACK_CRC_EN
      crc_ld_d    = crc_ld_q;
      crc_rb_d    = crc_rb_q;
      rb_cnt_d    = rb_cnt_q;
      error_d     = error_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StLoad;
               bit_cnt_d  = '0;
               wcnt_d     = '0;
               shreg_d    = '0;
               buf_d      = '0;
               buf_full_d = 1'b0;
               sh_left_d  = '0;
`ifdef CCFF_READBACK_CRC_EN
               crc_ld_d   = '0;
               crc_rb_d   = '0;
               rb_cnt_d   = '0;
               error_d    = 1'b0;
`endif
            end
         end

         StLoad: begin
            busy      = 1'b1;
            cfg_ready = !buf_full_q && (wcnt_q < WcntW'(NumWords));
            accept    = cfg_valid && cfg_ready;
            shift     = (sh_left_q != '0);
            ccff_en   = shift;
            ccff_head = shift & shreg_q[WORD_W-1];

            if (shift) begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
`ifdef CCFF_READBACK_CRC_EN
               crc_ld_d  = crc8_step(crc_ld_q, shreg_q[WORD_W-1]);
`endif
            end
            if (accept) begin
               wcnt_d = wcnt_q + WcntW'(1);
            end

            // Bits still owed to the chain after this cycle; trims the final partial word.
            rem    = CHAIN_LEN - 32'(bit_cnt_d);
            load_n = (rem < WORD_W) ? SlW'(rem) : SlW'(WORD_W);

            shreg_empty = (sh_left_q == '0) || (sh_left_q == SlW'(1));
            if (shreg_empty) begin
               if (buf_full_q) begin
                  shreg_d    = buf_q;
                  sh_left_d  = load_n;
                  buf_full_d = 1'b0;
               end else if (accept) begin
                  shreg_d   = cfg_data;
                  sh_left_d = load_n;
               end else begin
                  shreg_d   = '0;
                  sh_left_d = '0;
               end
            end else begin
               shreg_d   = shreg_q << 1;
               sh_left_d = sh_left_q - SlW'(1);
               if (accept) begin
                  buf_d      = cfg_data;
                  buf_full_d = 1'b1;
               end
            end

            if (bit_cnt_d == CNT_W'(CHAIN_LEN)) begin
`ifdef CCFF_READBACK_CRC_EN
               state_d  = StRback;
               rb_cnt_d = '0;
               crc_rb_d = '0;
`else
               state_d  = StFin;
`endif
            end
         end

`ifdef CCFF_READBACK_CRC_EN
         StRback: begin
            // Tail loops back to head, so one full rotation restores the image.
            busy      = 1'b1;
            ccff_en   = 1'b1;
            ccff_head = ccff_tail;
            crc_rb_d  = crc8_step(crc_rb_q, ccff_tail);
            rb_cnt_d  = rb_cnt_q + CNT_W'(1);
            if (rb_cnt_d == CNT_W'(CHAIN_LEN)) begin
               state_d = StFin;
               if (crc_rb_d != crc_ld_q) begin
                  error_d = 1'b1;
               end
            end
         end
`endif

         StFin: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         wcnt_q     <= '0;
         shreg_q    <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         sh_left_q  <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         wcnt_q     <= wcnt_d;
         shreg_q    <= shreg_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         sh_left_q  <= sh_left_d;
      end
   end

`ifdef CCFF_READBACK_CRC_EN
   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         crc_ld_q <= '0;
         crc_rb_q <= '0;
         rb_cnt_q <= '0;
         error_q  <= 1'b0;
      end else begin
         crc_ld_q <= crc_ld_d;
         crc_rb_q <= crc_rb_d;
         rb_cnt_q <= rb_cnt_d;
         error_q  <= error_d;
      end
   end
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: three chain geometries, each with a behavioural chain.
module tb_ccff_bitstream_loader;

`ifdef CCFF_READBACK_CRC_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif
   localparam int          EN16      = 16 * (1 + RB);
   localparam logic [15:0] HEAD16_HI = (RB == 1) ? 16'hA53C : 16'h0000;

   logic prog_clk = 1'b0;
   logic pReset;
   always #5 prog_clk = ~prog_clk;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // CHAIN_LEN=16, WORD_W=8
   logic       start16, valid16, ready16, head16, en16, tail16, busy16, done16, err16, flip16;
   logic [7:0] data16;
   // CHAIN_LEN=10, WORD_W=4
   logic       start10, valid10, ready10, head10, en10, tail10, busy10, done10, err10;
   logic [3:0] data10;
   // CHAIN_LEN=8, WORD_W=4
   logic       start8, valid8, ready8, head8, en8, tail8, busy8, done8, err8;
   logic [3:0] data8;

   ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) u16 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start16), .cfg_data(data16),
      .cfg_valid(valid16), .cfg_ready(ready16), .ccff_head(head16), .ccff_en(en16),
      .ccff_tail(tail16), .busy(busy16), .done(done16), .error(err16));

   ccff_bitstream_loader #(.CHAIN_LEN(10), .WORD_W(4)) u10 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start10), .cfg_data(data10),
      .cfg_valid(valid10), .cfg_ready(ready10), .ccff_head(head10), .ccff_en(en10),
      .ccff_tail(tail10), .busy(busy10), .done(done10), .error(err10));

   ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(4)) u8 (
      .prog_clk(prog_clk), .pReset(pReset), .start(start8), .cfg_data(data8),
      .cfg_valid(valid8), .cfg_ready(ready8), .ccff_head(head8), .ccff_en(en8),
      .ccff_tail(tail8), .busy(busy8), .done(done8), .error(err8));

   // Behavioural chains: head/en captured mid-cycle, chain advances on the rising edge.
   logic [15:0] chain16 = '0;
   logic [9:0]  chain10 = '0;
   logic [7:0]  chain8  = '0;
   logic en16_s = 1'b0, hd16_s = 1'b0, en10_s = 1'b0, hd10_s = 1'b0, en8_s = 1'b0, hd8_s = 1'b0;

   always @(negedge prog_clk) begin
      en16_s <= en16; hd16_s <= head16;
      en10_s <= en10; hd10_s <= head10;
      en8_s  <= en8;  hd8_s  <= head8;
   end
   always @(posedge prog_clk) begin
      if (en16_s) chain16 <= {chain16[14:0], hd16_s};
      if (en10_s) chain10 <= {chain10[8:0], hd10_s};
      if (en8_s)  chain8  <= {chain8[6:0], hd8_s};
   end
   assign tail16 = chain16[15] ^ flip16;
   assign tail10 = chain10[9];
   assign tail8  = chain8[7];

   // Results of the most recent run_load16
   int          r16_en_n, r16_first_en, r16_last_en, r16_first_xfer, r16_done_at, r16_done_n;
   int          r16_words;
   logic [31:0] r16_head;
   logic        r16_busy_after, r16_err_start, r16_err_at_done, r16_err_after;

   // Loads 0xA5, 0x3C into u16 with valid held high (0xFF offered afterwards).
   task automatic run_load16(input bit poke_start, input bit flip_rb);
      bit xfer;
      bit flipped;
      flipped        = 1'b0;
      r16_en_n       = 0;
      r16_first_en   = -1;
      r16_last_en    = -1;
      r16_first_xfer = -1;
      r16_done_at    = -1;
      r16_done_n     = 0;
      r16_words      = 0;
      r16_head       = '0;
      r16_err_start  = 1'b1;
      r16_err_at_done = 1'b0;
      @(posedge prog_clk); #1 start16 = 1'b1;
      @(posedge prog_clk); #1 start16 = 1'b0; valid16 = 1'b1; data16 = 8'hA5;
      for (int i = 0; i < 80; i++) begin
         @(negedge prog_clk);
         if (i == 0) r16_err_start = err16;
         if (en16) begin
            if (r16_first_en < 0) r16_first_en = i;
            r16_last_en = i;
            r16_en_n++;
            r16_head = {r16_head[30:0], head16};
         end
         if (done16) begin
            r16_done_n++;
            r16_done_at     = i;
            r16_err_at_done = err16;
         end
         xfer = valid16 && ready16;
         if (xfer && r16_first_xfer < 0) r16_first_xfer = i;
         @(posedge prog_clk); #1;
         start16 = 1'b0;
         flip16  = 1'b0;
         if (xfer) begin
            r16_words++;
            data16 = (r16_words == 1) ? 8'h3C : 8'hFF;
         end
         if (poke_start && (i == 3 || i == 10)) start16 = 1'b1;
         if (flip_rb && !flipped && r16_en_n == 20) begin
            flip16  = 1'b1;
            flipped = 1'b1;
         end
         if (r16_done_at >= 0 && i == r16_done_at + 2) break;
      end
      @(negedge prog_clk);
      r16_busy_after = busy16;
      r16_err_after  = err16;
      valid16 = 1'b0;
   endtask

   task automatic test_reset();
      #1 pReset = 1'b1;
      #2;
      total_cnt++;
      if ({ready16, en16, head16, busy16, done16, err16} !== 6'b0)
         $display("FAIL reset_u16: got %b expected 000000", {ready16, en16, head16, busy16, done16, err16});
      else pass_cnt++;
      total_cnt++;
      if ({ready10, en10, head10, busy10, done10, err10} !== 6'b0)
         $display("FAIL reset_u10: got %b expected 000000", {ready10, en10, head10, busy10, done10, err10});
      else pass_cnt++;
      total_cnt++;
      if ({ready8, en8, head8, busy8, done8, err8} !== 6'b0)
         $display("FAIL reset_u8: got %b expected 000000", {ready8, en8, head8, busy8, done8, err8});
      else pass_cnt++;
      @(negedge prog_clk);
      @(negedge prog_clk);
      pReset = 1'b0;
   endtask

   task automatic test_load16();
      run_load16(1'b0, 1'b0);
      total_cnt++;
      if (r16_en_n !== EN16) $display("FAIL load16_en_count: got %0d expected %0d", r16_en_n, EN16);
      else pass_cnt++;
      total_cnt++;
      if (r16_last_en - r16_first_en !== EN16 - 1)
         $display("FAIL load16_en_consecutive: got span %0d expected %0d", r16_last_en - r16_first_en, EN16 - 1);
      else pass_cnt++;
      total_cnt++;
      if (r16_first_en !== r16_first_xfer + 1)
         $display("FAIL load16_first_en_latency: got cycle %0d expected %0d", r16_first_en, r16_first_xfer + 1);
      else pass_cnt++;
      total_cnt++;
      if (r16_head[15:0] !== 16'hA53C) $display("FAIL load16_head_bits: got %h expected a53c", r16_head[15:0]);
      else pass_cnt++;
      total_cnt++;
      if (r16_head[31:16] !== HEAD16_HI)
         $display("FAIL load16_head_extra: got %h expected %h", r16_head[31:16], HEAD16_HI);
      else pass_cnt++;
      total_cnt++;
      if (r16_words !== 2) $display("FAIL load16_words: got %0d expected 2", r16_words);
      else pass_cnt++;
      total_cnt++;
      if (r16_done_n !== 1) $display("FAIL load16_done_pulses: got %0d expected 1", r16_done_n);
      else pass_cnt++;
      total_cnt++;
      if (r16_done_at !== r16_last_en + 1)
         $display("FAIL load16_done_timing: got cycle %0d expected %0d", r16_done_at, r16_last_en + 1);
      else pass_cnt++;
      total_cnt++;
      if (r16_busy_after !== 1'b0) $display("FAIL load16_busy_after: got %b expected 0", r16_busy_after);
      else pass_cnt++;
      total_cnt++;
      if (chain16 !== 16'hA53C) $display("FAIL load16_chain: got %h expected a53c", chain16);
      else pass_cnt++;
      total_cnt++;
      if (r16_err_at_done !== 1'b0) $display("FAIL load16_error: got %b expected 0", r16_err_at_done);
      else pass_cnt++;
   endtask

   task automatic test_partial_word();
      int words = 0, en_n = 0, done_n = 0, done_at = -1, late_ready = 0;
      logic [31:0] hb = '0;
      bit xfer;
      @(posedge prog_clk); #1 start10 = 1'b1;
      @(posedge prog_clk); #1 start10 = 1'b0; valid10 = 1'b1; data10 = 4'hF;
      for (int i = 0; i < 60; i++) begin
         @(negedge prog_clk);
         if (en10) begin
            en_n++;
            hb = {hb[30:0], head10};
         end
         if (done10) begin
            done_n++;
            done_at = i;
         end
         if (words >= 3 && ready10) late_ready++;
         xfer = valid10 && ready10;
         @(posedge prog_clk); #1;
         if (xfer) begin
            words++;
            data10 = (words == 1) ? 4'h0 : (words == 2) ? 4'hB : 4'h5;
         end
         if (done_at >= 0 && i == done_at + 2) break;
      end
      @(negedge prog_clk);
      total_cnt++;
      if (words !== 3) $display("FAIL partial_words: got %0d expected 3", words);
      else pass_cnt++;
      total_cnt++;
      if (late_ready !== 0) $display("FAIL partial_extra_ready: got %0d cycles expected 0", late_ready);
      else pass_cnt++;
      total_cnt++;
      if (en_n !== 10 * (1 + RB)) $display("FAIL partial_en_count: got %0d expected %0d", en_n, 10 * (1 + RB));
      else pass_cnt++;
      total_cnt++;
      if (hb[9:0] !== 10'b1111000010) $display("FAIL partial_head_bits: got %b expected 1111000010", hb[9:0]);
      else pass_cnt++;
      total_cnt++;
      if (chain10 !== 10'b1111000010) $display("FAIL partial_chain: got %b expected 1111000010", chain10);
      else pass_cnt++;
      total_cnt++;
      if (done_n !== 1) $display("FAIL partial_done_pulses: got %0d expected 1", done_n);
      else pass_cnt++;
      total_cnt++;
      if ({busy10, err10} !== 2'b00) $display("FAIL partial_idle_after: got %b expected 00", {busy10, err10});
      else pass_cnt++;
      valid10 = 1'b0;
   endtask

   task automatic test_starvation();
      int words = 0, seen = 0, gap = 0, gap_head = 0, done_n = 0, done_at = -1, i0 = -1;
      logic [31:0] hb = '0;
      bit xfer;
      @(posedge prog_clk); #1 start8 = 1'b1;
      @(posedge prog_clk); #1 start8 = 1'b0; valid8 = 1'b1; data8 = 4'h9;
      for (int i = 0; i < 60; i++) begin
         @(negedge prog_clk);
         if (!en8 && seen == 4) begin
            gap++;
            if (head8) gap_head++;
         end
         if (en8) begin
            seen++;
            hb = {hb[30:0], head8};
         end
         if (done8) begin
            done_n++;
            done_at = i;
         end
         xfer = valid8 && ready8;
         if (xfer && i0 < 0) i0 = i;
         @(posedge prog_clk); #1;
         if (xfer) begin
            words++;
            valid8 = 1'b0;
         end
         // Second word appears three cycles after the shifter runs dry.
         if (words == 1 && i0 >= 0 && i + 1 == i0 + 7) begin
            valid8 = 1'b1;
            data8  = 4'h6;
         end
         if (done_at >= 0 && i == done_at + 2) break;
      end
      total_cnt++;
      if (gap !== 3) $display("FAIL starve_gap: got %0d cycles expected 3", gap);
      else pass_cnt++;
      total_cnt++;
      if (gap_head !== 0) $display("FAIL starve_head_idle: got %0d high cycles expected 0", gap_head);
      else pass_cnt++;
      total_cnt++;
      if (seen !== 8 * (1 + RB)) $display("FAIL starve_en_count: got %0d expected %0d", seen, 8 * (1 + RB));
      else pass_cnt++;
      total_cnt++;
      if (hb[7:0] !== 8'h96) $display("FAIL starve_head_bits: got %h expected 96", hb[7:0]);
      else pass_cnt++;
      total_cnt++;
      if (chain8 !== 8'h96) $display("FAIL starve_chain: got %h expected 96", chain8);
      else pass_cnt++;
      total_cnt++;
      if (done_n !== 1) $display("FAIL starve_done_pulses: got %0d expected 1", done_n);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_load();
      int seen = 0;
      @(posedge prog_clk); #1 start16 = 1'b1;
      @(posedge prog_clk); #1 start16 = 1'b0; valid16 = 1'b1; data16 = 8'hA5;
      for (int i = 0; i < 40; i++) begin
         @(negedge prog_clk);
         if (en16) seen++;
         @(posedge prog_clk);
         if (seen == 5) break;
      end
      #2 pReset = 1'b1;
      #1;
      total_cnt++;
      if (seen !== 5) $display("FAIL midreset_shift_count: got %0d expected 5", seen);
      else pass_cnt++;
      total_cnt++;
      if ({ready16, en16, head16, busy16, done16, err16} !== 6'b0)
         $display("FAIL midreset_outputs: got %b expected 000000", {ready16, en16, head16, busy16, done16, err16});
      else pass_cnt++;
      @(negedge prog_clk);
      valid16 = 1'b0;
      pReset  = 1'b0;
      run_load16(1'b0, 1'b0);
      total_cnt++;
      if (r16_en_n !== EN16) $display("FAIL midreset_reload_en: got %0d expected %0d", r16_en_n, EN16);
      else pass_cnt++;
      total_cnt++;
      if (chain16 !== 16'hA53C) $display("FAIL midreset_reload_chain: got %h expected a53c", chain16);
      else pass_cnt++;
      total_cnt++;
      if (r16_done_n !== 1) $display("FAIL midreset_reload_done: got %0d expected 1", r16_done_n);
      else pass_cnt++;
   endtask

   task automatic test_ignored_inputs();
      @(posedge prog_clk); #1 valid16 = 1'b1; data16 = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge prog_clk);
         total_cnt++;
         if ({ready16, busy16, en16} !== 3'b000)
            $display("FAIL idle_valid_ignored: got ready/busy/en %b expected 000", {ready16, busy16, en16});
         else pass_cnt++;
      end
      run_load16(1'b1, 1'b0);
      total_cnt++;
      if (r16_en_n !== EN16) $display("FAIL busy_start_en: got %0d expected %0d", r16_en_n, EN16);
      else pass_cnt++;
      total_cnt++;
      if (r16_head[15:0] !== 16'hA53C) $display("FAIL busy_start_head: got %h expected a53c", r16_head[15:0]);
      else pass_cnt++;
      total_cnt++;
      if (r16_done_n !== 1) $display("FAIL busy_start_done: got %0d expected 1", r16_done_n);
      else pass_cnt++;
      total_cnt++;
      if (r16_busy_after !== 1'b0) $display("FAIL busy_start_restart: got busy %b expected 0", r16_busy_after);
      else pass_cnt++;
      total_cnt++;
      if (chain16 !== 16'hA53C) $display("FAIL busy_start_chain: got %h expected a53c", chain16);
      else pass_cnt++;
   endtask

`ifdef CCFF_READBACK_CRC_EN
   task automatic test_crc_readback();
      run_load16(1'b0, 1'b1);
      total_cnt++;
      if (r16_err_at_done !== 1'b1) $display("FAIL crc_flip_error_at_done: got %b expected 1", r16_err_at_done);
      else pass_cnt++;
      total_cnt++;
      if (r16_err_after !== 1'b1) $display("FAIL crc_flip_error_sticky: got %b expected 1", r16_err_after);
      else pass_cnt++;
      total_cnt++;
      if (r16_done_n !== 1) $display("FAIL crc_flip_done: got %0d expected 1", r16_done_n);
      else pass_cnt++;
      run_load16(1'b0, 1'b0);
      total_cnt++;
      if (r16_err_start !== 1'b0) $display("FAIL crc_error_cleared_by_start: got %b expected 0", r16_err_start);
      else pass_cnt++;
      total_cnt++;
      if (r16_err_at_done !== 1'b0) $display("FAIL crc_clean_error: got %b expected 0", r16_err_at_done);
      else pass_cnt++;
      total_cnt++;
      if (chain16 !== 16'hA53C) $display("FAIL crc_clean_chain: got %h expected a53c", chain16);
      else pass_cnt++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pReset  = 1'b0;
      start16 = 1'b0; valid16 = 1'b0; data16 = '0; flip16 = 1'b0;
      start10 = 1'b0; valid10 = 1'b0; data10 = '0;
      start8  = 1'b0; valid8  = 1'b0; data8  = '0;
      test_reset();
      test_load16();
      test_partial_word();
      test_starvation();
      test_reset_mid_load();
      test_ignored_inputs();
`ifdef CCFF_READBACK_CRC_EN
      test_crc_readback();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
